// File: rtl/regs_ctx_switch_if.sv
// Bus bundle between the context-switch controller and its neighbours:
// the warp scheduler (swap requests), the work queue (context preload) and
// the register file's bulk read/write ports.
// Optional feature macro: CTX_SWAP_CNT_EN adds the swap_count output.
interface regs_ctx_switch_if #(
  parameter int IDW = 2
);
  logic           swap_req;
  logic [IDW-1:0] swap_id;
  logic           pipe_idle;
  logic           busy;
  logic           stall;
  logic           swap_done;
  logic [IDW-1:0] cur_id;
  logic           give_me;
  logic [255:0]   the_regs;
  logic           writing_regs;
  logic [255:0]   change_me;
  logic           ctx_wr_en;
  logic [IDW-1:0] ctx_wr_id;
  logic [255:0]   ctx_wr_data;
  logic           ctx_wr_err;
`ifdef CTX_SWAP_CNT_EN
  logic [15:0]    swap_count;
`endif

`ifdef CTX_SWAP_CNT_EN
  modport master (
    output swap_req, swap_id, pipe_idle, the_regs, ctx_wr_en, ctx_wr_id, ctx_wr_data,
    input  busy, stall, swap_done, cur_id, give_me, writing_regs, change_me, ctx_wr_err,
           swap_count
  );
  modport slave (
    input  swap_req, swap_id, pipe_idle, the_regs, ctx_wr_en, ctx_wr_id, ctx_wr_data,
    output busy, stall, swap_done, cur_id, give_me, writing_regs, change_me, ctx_wr_err,
           swap_count
  );
`else
  modport master (
    output swap_req, swap_id, pipe_idle, the_regs, ctx_wr_en, ctx_wr_id, ctx_wr_data,
    input  busy, stall, swap_done, cur_id, give_me, writing_regs, change_me, ctx_wr_err
  );
  modport slave (
    input  swap_req, swap_id, pipe_idle, the_regs, ctx_wr_en, ctx_wr_id, ctx_wr_data,
    output busy, stall, swap_done, cur_id, give_me, writing_regs, change_me, ctx_wr_err
  );
`endif
endinterface

// File: rtl/regs_ctx_switch.sv
// Context-switch controller for the 16x32 register file.
// Keeps NCTX saved 256-bit contexts (regs 0..7, reg0 in the MSBs). A swap
// stalls the pipeline, waits for in-flight writes to drain, snapshots the live
// registers over the bulk-read bus and bulk-writes the target context.
// Optional feature macro: CTX_SWAP_CNT_EN adds a saturating 16-bit count of
// swaps that reached the LOAD phase.
module regs_ctx_switch #(
  parameter int NCTX = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  regs_ctx_switch_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    SNAP  = 3'd2,
    CAPT  = 3'd3,
    LOAD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic           accept_s;
  logic [IDW-1:0] tgt_r;
  logic [IDW-1:0] cur_id_r;
  logic [255:0]   store_r [NCTX];
  logic [255:0]   change_me_r;
  logic           wr_drop_s;

  logic busy_s, stall_s, give_me_s, writing_s, done_s;
  logic busy_r, stall_r, give_me_r, writing_r, done_r, err_r;

  // A preload into the resident slot is refused: the register file holds the
  // authoritative copy, and any CAPT write targets this same slot anyway.
  assign wr_drop_s = bus.ctx_wr_en && (bus.ctx_wr_id == cur_id_r);

  // Next-state decode; a request is only looked at while idle.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.swap_req) begin
          accept_s = 1'b1;
          if (bus.swap_id != cur_id_r) begin
            state_s = DRAIN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (bus.pipe_idle) begin
          state_s = SNAP;
        end else begin
          state_s = DRAIN;
        end
      end
      SNAP:    state_s = CAPT;
      CAPT:    state_s = LOAD;
      LOAD:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so outputs can be registered and
  // still line up with the state they describe.
  always_comb begin
    busy_s    = (state_s != IDLE);
    stall_s   = 1'b0;
    give_me_s = 1'b0;
    writing_s = 1'b0;
    done_s    = 1'b0;
    case (state_s)
      DRAIN: begin
        stall_s = 1'b1;
      end
      SNAP, CAPT: begin
        stall_s   = 1'b1;
        give_me_s = 1'b1;
      end
      LOAD: begin
        stall_s   = 1'b1;
        writing_s = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // State register and registered control outputs; async reset drops
  // writing_regs immediately if a swap is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      stall_r   <= 1'b0;
      give_me_r <= 1'b0;
      writing_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= busy_s;
      stall_r   <= stall_s;
      give_me_r <= give_me_s;
      writing_r <= writing_s;
      done_r    <= done_s;
      err_r     <= wr_drop_s;
    end
  end

  // Target id is frozen at acceptance; resident id follows it when DONE ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_r    <= {IDW{1'b0}};
      cur_id_r <= {IDW{1'b0}};
    end else begin
      if (accept_s) begin
        tgt_r <= bus.swap_id;
      end
      if (state_r == DONE) begin
        cur_id_r <= tgt_r;
      end
    end
  end

  // Context store: CAPT snapshots the live registers, preloads fill other slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCTX; i++) begin
        store_r[i] <= {256{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        if ((state_r == CAPT) && (cur_id_r == IDW'(i))) begin
          store_r[i] <= bus.the_regs;
        end else if (bus.ctx_wr_en && !wr_drop_s && (bus.ctx_wr_id == IDW'(i))) begin
          store_r[i] <= bus.ctx_wr_data;
        end
      end
    end
  end

  // Load data is read once at CAPT; later preloads to the target do not
  // disturb the LOAD that is already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_me_r <= {256{1'b0}};
    end else if (state_r == CAPT) begin
      change_me_r <= store_r[tgt_r];
    end
  end

`ifdef CTX_SWAP_CNT_EN
  logic [15:0] swap_count_r;

  // Counts swaps entering LOAD (same-id swaps never do), saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_count_r <= 16'h0000;
    end else if ((state_r == CAPT) && (swap_count_r != 16'hFFFF)) begin
      swap_count_r <= swap_count_r + 16'h0001;
    end
  end

  assign bus.swap_count = swap_count_r;
`endif

  assign bus.busy         = busy_r;
  assign bus.stall        = stall_r;
  assign bus.give_me      = give_me_r;
  assign bus.writing_regs = writing_r;
  assign bus.swap_done    = done_r;
  assign bus.ctx_wr_err   = err_r;
  assign bus.cur_id       = cur_id_r;
  assign bus.change_me    = change_me_r;

endmodule

// File: tb/tb_regs_ctx_switch.sv
// Self-checking bench for regs_ctx_switch: a small register-file model feeds
// the_regs and absorbs bulk writes; expected load data is queued when a swap
// is requested and compared when writing_regs fires.
`timescale 1ns/1ps
module tb_regs_ctx_switch;
  localparam int IDW  = 2;
  localparam int NCTX = 4;
  localparam logic [255:0] A_VALS = {32'hA0, 32'hA1, 32'hA2, 32'hA3,
                                     32'hA4, 32'hA5, 32'hA6, 32'hA7};
  localparam logic [255:0] ONES   = {8{32'h1111_1111}};
  localparam logic [255:0] B_VALS = {8{32'h0B0B_C0DE}};
  localparam logic [255:0] JUNK   = {8{32'hDEAD_BEEF}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regs_ctx_switch_if #(.IDW(IDW)) bus ();
  regs_ctx_switch #(.NCTX(NCTX), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0]   exp_q [$];
  logic [255:0]   m_store [NCTX];
  logic [IDW-1:0] m_cur;
  int             m_cnt;

  logic [255:0] rf         = {256{1'b0}};
  logic         rf_set     = 1'b0;
  logic [255:0] rf_set_val = {256{1'b0}};

  assign bus.the_regs = rf;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Register file model: tb-forced value or bulk write from the controller.
  always @(posedge clk) begin
    if (rf_set) rf <= rf_set_val;
    else if (bus.writing_regs) rf <= bus.change_me;
  end

  // Scoreboard: every bulk write must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.writing_regs) begin
      if (exp_q.size() == 0) check("ld_unexpected", 256'(bus.writing_regs), 256'(0));
      else check("ld_data", bus.change_me, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_rf(input logic [255:0] v);
    rf_set = 1'b1; rf_set_val = v;
    @(posedge clk); #1;
    rf_set = 1'b0;
  endtask

  task automatic preload(input logic [IDW-1:0] id, input logic [255:0] d);
    bit hit;
    hit = (id == m_cur);
    bus.ctx_wr_en = 1'b1; bus.ctx_wr_id = id; bus.ctx_wr_data = d;
    @(posedge clk); #1;
    bus.ctx_wr_en = 1'b0;
    @(negedge clk);
    check("wr_err", 256'(bus.ctx_wr_err), 256'(hit));
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_err_clr", 256'(bus.ctx_wr_err), 256'(0));
    @(posedge clk); #1;
    if (!hit) m_store[id] = d;
  endtask

  // One swap; cycle c counts from the cycle after swap_req (T+c).
  task automatic do_swap(input logic [IDW-1:0] id, input int idle_wait,
                         input bit redo, input bit wr_hit, input bit abort);
    bit             same;
    int             dexp;
    logic [IDW-1:0] old;
    logic [255:0]   cap;
    logic [5:0]     ctl_e;
    old  = m_cur;
    same = (id == old);
    dexp = same ? 1 : idle_wait + 5;
    cap  = rf;
    if (!same) exp_q.push_back(m_store[id]);
    bus.swap_req = 1'b1; bus.swap_id = id; bus.pipe_idle = (idle_wait == 0);
    @(posedge clk); #1;
    bus.swap_req = 1'b0;
    if (redo) bus.swap_id = id + 2'd1;
    for (int c = 1; c <= dexp + 1; c++) begin
      if (!same) bus.pipe_idle = (c > idle_wait);
      if (redo && c == 2) begin bus.swap_req = 1'b1; bus.swap_id = id ^ 2'd2; end
      if (redo && c == 3) bus.swap_req = 1'b0;
      if (wr_hit) begin
        bus.ctx_wr_en = (c == dexp - 2); bus.ctx_wr_id = old; bus.ctx_wr_data = JUNK;
      end
      @(negedge clk);
      ctl_e = {c <= dexp, !same && c <= dexp - 1, !same && (c == dexp - 3 || c == dexp - 2),
               !same && c == dexp - 1, c == dexp, wr_hit && c == dexp - 1};
      check($sformatf("ctl id%0d c%0d", id, c),
            256'({bus.busy, bus.stall, bus.give_me, bus.writing_regs, bus.swap_done, bus.ctx_wr_err}),
            256'(ctl_e));
      check($sformatf("cur_id id%0d c%0d", id, c), 256'(bus.cur_id), 256'((c <= dexp) ? old : id));
      if (abort && c == dexp - 1) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_ctl", 256'({bus.busy, bus.stall, bus.give_me, bus.writing_regs,
                                 bus.swap_done, bus.ctx_wr_err}), 256'(0));
        check("abort_cur", 256'(bus.cur_id), 256'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < NCTX; k++) m_store[k] = {256{1'b0}};
        m_cur = '0; m_cnt = 0; exp_q.delete();
        return;
      end
      @(posedge clk); #1;
    end
    bus.ctx_wr_en = 1'b0;
    bus.pipe_idle = 1'b1;
    if (!same) begin
      m_store[old] = cap;
      m_cur = id;
      m_cnt++;
    end
  endtask

  initial begin
    bus.swap_req = 1'b0; bus.swap_id = '0; bus.pipe_idle = 1'b1;
    bus.ctx_wr_en = 1'b0; bus.ctx_wr_id = '0; bus.ctx_wr_data = {256{1'b0}};
    for (int k = 0; k < NCTX; k++) m_store[k] = {256{1'b0}};
    m_cur = '0; m_cnt = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ctl", 256'({bus.busy, bus.stall, bus.give_me, bus.writing_regs,
                           bus.swap_done, bus.ctx_wr_err}), 256'(0));
    check("rst_cur", 256'(bus.cur_id), 256'(0));
    check("rst_change_me", bus.change_me, {256{1'b0}});
`ifdef CTX_SWAP_CNT_EN
    check("rst_count", 256'(bus.swap_count), 256'(0));
`endif
    @(posedge clk); #1;

    preload(2'd1, ONES);
    preload(2'd0, JUNK);
    set_rf(A_VALS);
    do_swap(2'd1, 0, 1'b0, 1'b0, 1'b0);
    check("rf_after_swap1", rf, ONES);
    do_swap(2'd0, 0, 1'b0, 1'b0, 1'b0);
    check("rf_restore0", rf, A_VALS);
    do_swap(2'd2, 6, 1'b0, 1'b0, 1'b0);
    do_swap(2'd2, 0, 1'b0, 1'b0, 1'b0);
    set_rf(B_VALS);
    do_swap(2'd3, 3, 1'b1, 1'b1, 1'b0);
    do_swap(2'd2, 0, 1'b0, 1'b0, 1'b0);
    check("capture_kept", rf, B_VALS);
`ifdef CTX_SWAP_CNT_EN
    check("count_pre_abort", 256'(bus.swap_count), 256'(m_cnt));
`endif
    do_swap(2'd1, 0, 1'b0, 1'b0, 1'b1);
    do_swap(2'd1, 0, 1'b0, 1'b0, 1'b0);
    check("store_cleared", rf, {256{1'b0}});
    do_swap(2'd2, 0, 1'b0, 1'b0, 1'b0);
    do_swap(2'd2, 0, 1'b0, 1'b0, 1'b0);
    do_swap(2'd3, 2, 1'b0, 1'b0, 1'b0);
    check("queue_drained", 256'(exp_q.size()), 256'(0));
`ifdef CTX_SWAP_CNT_EN
    check("count_final", 256'(bus.swap_count), 256'(m_cnt));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regs_ctx_switch.md
Name: regs_ctx_switch

Overview:
- Context-switch controller for the 16x32 register file.
- Holds NCTX saved 256-bit contexts: registers 0..7, packed with reg0 in the MSBs, matching the file's bulk bus.
- On a swap request it:
  - stalls the pipeline and waits for it to drain;
  - snapshots the live registers through the bulk-read bus;
  - bulk-writes the target context.
- Sits between the warp scheduler/work queue and the register file's bulk read/write ports.

Parameters:
- NCTX, 4, number of context slots (power of 2, >=2).
- IDW, 2, context id width, equal to log2(NCTX).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- swap_req  in  1  request swap to swap_id; sampled only when busy=0.
- swap_id  in  IDW  target context.
- pipe_idle  in  1  pipeline has no register write in flight.
- busy  out  1  swap in progress.
- stall  out  1  hold pipeline issue.
- swap_done  out  1  one-cycle pulse at swap completion.
- cur_id  out  IDW  context currently resident in the register file.
- give_me  out  1  bulk-read enable to the register file.
- the_regs  in  256  bulk snapshot from the register file; valid one cycle after the last write lands.
- writing_regs  out  1  bulk-write strobe to the register file.
- change_me  out  256  bulk-write data.
- ctx_wr_en  in  1  preload a slot from the work queue.
- ctx_wr_id  in  IDW  preload slot.
- ctx_wr_data  in  256  preload data.
- ctx_wr_err  out  1  one-cycle pulse when a preload is dropped.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cur_id=0, all store slots=0.
  - busy, stall, swap_done, give_me, writing_regs, ctx_wr_err=0; change_me=0.
  - Reset mid-swap aborts immediately: writing_regs deasserts asynchronously and no partial capture is kept.
- States: IDLE, DRAIN, SNAP, CAPT, LOAD, DONE. busy=1 in every state except IDLE.
- IDLE:
  - swap_req=1 with swap_id!=cur_id -> DRAIN.
  - swap_req=1 with swap_id==cur_id -> DONE directly. No stall, no register traffic; swap_done pulses next cycle.
- DRAIN:
  - stall=1.
  - Stays in DRAIN while pipe_idle=0. When pipe_idle=1 -> SNAP.
  - swap_id is latched on entry to DRAIN; later swap_id changes are ignored.
- SNAP: stall=1, give_me=1. One-cycle wait so the_regs reflects the final write. -> CAPT.
- CAPT:
  - stall=1, give_me=1.
  - store[cur_id] <= the_regs.
  - change_me <= store[latched id], registered here.
  - -> LOAD.
- LOAD: stall=1, writing_regs=1 for exactly one cycle. -> DONE.
- DONE:
  - stall=0, swap_done=1.
  - cur_id <= latched id, updating on exiting DONE.
  - -> IDLE.
- Latency with pipe_idle already high: swap_req cycle T, DRAIN T+1, SNAP T+2, CAPT T+3, LOAD T+4, swap_done at T+5.
- writing_regs and stall never assert in the same cycle as a pipeline write. The drain guarantees this.
- swap_req while busy=1: ignored, not queued.
- Preload rules:
  - ctx_wr_en writes store[ctx_wr_id] on the clock edge in any state.
  - ctx_wr_id==cur_id: write dropped, ctx_wr_err pulses. The live copy is authoritative.
  - Same slot as the CAPT write in the same cycle: capture wins, ctx_wr_err pulses.
  - Preload to the latched target after CAPT: stored, but the in-flight LOAD uses the value read at CAPT.
- NCTX wrap: ids are exactly IDW bits; no out-of-range ids exist.

Optional Feature:
- Macro CTX_SWAP_CNT_EN.
- Defined:
  - Adds output swap_count [15:0], reset 0.
  - Increments once per swap that reaches LOAD. Same-id swaps do not count.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then preload slot 1 with 256'h1111...1 and slot 0 write attempt -> slot 0 write dropped, ctx_wr_err=1 one cycle; cur_id=0.
- Swap 0->1 with pipe_idle=1 at cycle T, reg file holding 0xA0..0xA7 -> writing_regs at T+4 with change_me=1111...1, swap_done at T+5, cur_id=1. Then swap 1->0 restores 0xA0..0xA7.
- pipe_idle held 0 for 6 cycles after swap_req -> stall=1 throughout, give_me stays 0 until pipe_idle rises, swap_done exactly 4 cycles after pipe_idle=1.
- Swap to current id 2 -> swap_done next cycle; stall, give_me, writing_regs never assert; cur_id unchanged.
- Second swap_req and changing swap_id during DRAIN -> ignored; target is the id latched at the first request. Preload to slot==cur_id during CAPT -> capture value kept, ctx_wr_err pulses.
- rst_n low during LOAD -> writing_regs drops asynchronously, state IDLE, cur_id=0, store cleared. With CTX_SWAP_CNT_EN: three real swaps plus one same-id swap -> swap_count=3.
